seletor_teclado: RTL and testbench
==================================

// Module: seletor_teclado
// PURPOSE
// - Keypad-side producer for the row/column selection registers of the vending machine.
// - Filters four value keys plus confirm/cancel, then sequences a two-step selection:
//   row first, then column.
// - Drives code/enL/enC, which feed the linha/coluna register block directly.
// - Flags a complete selection and a purchase request to the main vending controller.
// PARAMETERS
// - DEBOUNCE_CYC  default 8      consecutive stable cycles needed to accept a press or a release
// - TIMEOUT_CYC   default 1000   idle cycles in S_COLUNA/S_PRONTO before the selection is abandoned
// PORTS
// - clk         in   1  system clock, rising edge
// - clr         in   1  asynchronous, active-high reset
// - tecla       in   4  value keys, one bit per key; bit i pressed = value i
// - confirma    in   1  confirm key, level; filtered like tecla
// - cancela     in   1  cancel key, level; filtered like tecla
// - code        out  2  selected value; valid in the enL/enC cycle and held afterwards
// - enL         out  1  one-cycle strobe: code is the row
// - enC         out  1  one-cycle strobe: code is the column
// - sel_valida  out  1  high while a complete row+column selection awaits confirmation
// - compra      out  1  one-cycle pulse: confirmed purchase of the held selection
// - expirou     out  1  one-cycle pulse: selection abandoned by timeout
// BEHAVIOUR
// - Reset state: state = S_LINHA, counters = 0, code = 2'b00.
// - Reset outputs: enL, enC, sel_valida, compra and expirou are all 0.
// - clr takes effect immediately from any state and discards a partial selection without a strobe.
// - Press acceptance:
//   - The filtered key is valid only when exactly one tecla bit is set and that pattern is
//     unchanged for DEBOUNCE_CYC consecutive cycles.
//   - Zero or multiple set bits, or any pattern change, restart the filter count.
// - Release: all tecla bits must read 0 for DEBOUNCE_CYC consecutive cycles before another
//   press is accepted. Holding a key never yields a second strobe.
// - States and transitions:
//   - S_LINHA: on an accepted press of value v, set code=v, pulse enL for 1 cycle, go to S_SOLTA_L.
//   - S_SOLTA_L: wait for a debounced release, then go to S_COLUNA.
//   - S_COLUNA: on an accepted press of v, set code=v, pulse enC, go to S_SOLTA_C.
//   - S_SOLTA_C: wait for a debounced release, then go to S_PRONTO.
//   - S_PRONTO: sel_valida=1. A debounced confirma pulses compra for 1 cycle and goes to S_LINHA.
// - Latency: an enL/enC strobe appears in the cycle after the DEBOUNCE_CYC-th stable sample.
// - enL and enC are never high in the same cycle, and never high while clr is asserted.
// - cancela: once debounced, it returns the FSM to S_LINHA from any state. No strobe, no compra.
// - Simultaneous confirma and cancela: cancela wins.
// - Timeout: the counter runs only in S_COLUNA and S_PRONTO.
//   - It is cleared on every state change and on any nonzero tecla activity.
//   - When it reaches TIMEOUT_CYC-1: pulse expirou, go to S_LINHA, drop sel_valida.
// - Simultaneous events:
//   - Timeout and an accepted press in the same cycle: the press wins and the counter restarts.
//   - Timeout and cancela together: cancela path; expirou stays low.
// - Width rules:
//   - Counters are sized $clog2(max(DEBOUNCE_CYC, TIMEOUT_CYC)+1).
//   - Counters saturate and never wrap.
//   - One-hot-to-binary: bit 0->00, 1->01, 2->10, 3->11.
// STRUCTURE
// - Shared package/header:
//   - state encoding (S_LINHA, S_SOLTA_L, S_COLUNA, S_SOLTA_C, S_PRONTO);
//   - one-hot->code decode function;
//   - a NUM_TECLAS=4 constant.
// - Sub-module filtro_tecla (width-parameterised stable-pattern debouncer, async clr).
//   - One instance for tecla[3:0].
//   - One instance each for confirma and cancela.
//   - Provides a stable pattern and a one-cycle accepted-edge pulse.
// - Top level holds the FSM, the timeout counter and the output registers.
// TESTING
// Tests use DEBOUNCE_CYC=4 and TIMEOUT_CYC=40.
// - Full selection:
//   - Stimulus: tecla=0010 for 6 cycles, release; then tecla=1000, release; then confirma.
//   - Response: enL with code=01, then enC with code=11; sel_valida=1; compra for 1 cycle;
//     back in S_LINHA.
// - Bounce rejection:
//   - Stimulus: tecla toggles 0100/0000 every 2 cycles for 20 cycles.
//   - Response: no enL. Then a stable 0100 for 4 cycles gives enL with code=10.
// - Multi-key and hold:
//   - tecla=0011 held 10 cycles -> no strobe.
//   - tecla=0001 held 50 cycles -> exactly one enL with code=00; no enC until release.
// - Timeout:
//   - Stimulus: row accepted, keys idle 40 cycles in S_COLUNA.
//   - Response: expirou for 1 cycle; the next press yields enL, not enC.
// - Cancel priority:
//   - confirma and cancela rise together in S_PRONTO -> no compra; sel_valida drops.
//   - cancela in S_COLUNA -> back to S_LINHA.
// - Async reset mid-operation:
//   - Stimulus: clr pulsed between clock edges while in S_SOLTA_C.
//   - Response: all outputs 0 immediately; code=00; S_LINHA after clr falls.

Source files
------------

// File: rtl/seletor_teclado_pkg.sv
// Shared definitions for the keypad selector: FSM state encoding, keypad width
// and the one-hot key to 2-bit value decode.
package seletor_teclado_pkg;

  localparam int NUM_TECLAS = 4;

  typedef enum logic [2:0] {
    S_LINHA   = 3'd0,
    S_SOLTA_L = 3'd1,
    S_COLUNA  = 3'd2,
    S_SOLTA_C = 3'd3,
    S_PRONTO  = 3'd4
  } estado_t;

  // Only ever called with an accepted (one-hot) pattern; anything else maps to 00.
  function automatic logic [1:0] onehot_para_code(input logic [NUM_TECLAS-1:0] oh);
    logic [1:0] v;
    case (oh)
      4'b0001: v = 2'b00;
      4'b0010: v = 2'b01;
      4'b0100: v = 2'b10;
      4'b1000: v = 2'b11;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seletor_teclado_filtro.sv
// filtro_tecla: width-parameterised stable-pattern debouncer.
// Ports:
//   clk, clr    clock, asynchronous active-high reset
//   i_bits      raw key levels
//   o_estavel   last accepted pattern (all zero = released)
//   o_aceito    one-cycle pulse, combinational, in the cycle whose closing edge
//               takes the DEBOUNCE_CYC-th stable sample of a new press
// A pattern with more than one bit set never counts as stable. A new press is
// only taken after the accepted pattern has returned to all zero.
module filtro_tecla #(
  parameter int W            = 1,
  parameter int DEBOUNCE_CYC = 8,
  parameter int CW           = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] i_bits,
  output logic [W-1:0] o_estavel,
  output logic         o_aceito
);

  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYC);

  logic [W-1:0]  r_amostra;
  logic [W-1:0]  r_estavel;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_novo;
  logic          w_valido;
  logic          w_muda;

  always_comb begin
    // zero or exactly one bit set
    w_valido   = ((i_bits & (i_bits - W'(1))) == '0);
    w_cnt_novo = '0;
    if (w_valido) begin
      if (i_bits != r_amostra)
        w_cnt_novo = CW'(1);
      else if (r_cnt >= DEB)
        w_cnt_novo = r_cnt;
      else
        w_cnt_novo = r_cnt + CW'(1);
    end
    w_muda = (w_cnt_novo == DEB) && (i_bits != r_estavel) &&
             ((i_bits == '0) || (r_estavel == '0));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_amostra <= '0;
      r_estavel <= '0;
      r_cnt     <= '0;
    end else begin
      r_amostra <= i_bits;
      r_cnt     <= w_cnt_novo;
      if (w_muda)
        r_estavel <= i_bits;
    end
  end

  assign o_estavel = r_estavel;
  assign o_aceito  = w_muda && (i_bits != '0);

endmodule

// File: rtl/seletor_teclado.sv
// seletor_teclado: keypad-side producer of the row/column selection.
// Ports:
//   clk, clr           clock, asynchronous active-high reset
//   tecla[3:0]         value keys (bit i = value i), confirma, cancela
//   code, enL, enC     selected value and row/column load strobes
//   sel_valida         complete selection waiting for confirmation
//   compra, expirou    purchase pulse, timeout pulse
// state     | meaning
// S_LINHA   | waiting for the row key
// S_SOLTA_L | row taken, waiting for key release
// S_COLUNA  | waiting for the column key (timeout runs)
// S_SOLTA_C | column taken, waiting for key release
// S_PRONTO  | selection complete, waiting for confirm (timeout runs)
module seletor_teclado
  import seletor_teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NUM_TECLAS-1:0] tecla,
  input  logic                  confirma,
  input  logic                  cancela,
  output logic [1:0]            code,
  output logic                  enL,
  output logic                  enC,
  output logic                  sel_valida,
  output logic                  compra,
  output logic                  expirou
);

  localparam int CNT_MAX = (DEBOUNCE_CYC > TIMEOUT_CYC) ? DEBOUNCE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TMO_FIM = CW'(TIMEOUT_CYC - 1);

  logic [NUM_TECLAS-1:0] w_tecla_est;
  logic                  w_tecla_ok, w_conf_ok, w_canc_ok;
  logic                  w_conf_est, w_canc_est;
  logic                  w_unused;

  estado_t       r_estado, w_prox;
  logic [CW-1:0] r_tmo, w_tmo_n;
  logic [1:0]    r_code, w_code_n;
  logic          r_enL, r_enC, r_compra, r_expirou;
  logic          w_enL_n, w_enC_n, w_compra_n, w_exp_n;
  logic          w_tmo_fim;

  filtro_tecla #(.W(NUM_TECLAS), .DEBOUNCE_CYC(DEBOUNCE_CYC), .CW(CW)) u_filtro_tecla (
    .clk(clk), .clr(clr), .i_bits(tecla), .o_estavel(w_tecla_est), .o_aceito(w_tecla_ok)
  );

  filtro_tecla #(.W(1), .DEBOUNCE_CYC(DEBOUNCE_CYC), .CW(CW)) u_filtro_confirma (
    .clk(clk), .clr(clr), .i_bits(confirma), .o_estavel(w_conf_est), .o_aceito(w_conf_ok)
  );

  filtro_tecla #(.W(1), .DEBOUNCE_CYC(DEBOUNCE_CYC), .CW(CW)) u_filtro_cancela (
    .clk(clk), .clr(clr), .i_bits(cancela), .o_estavel(w_canc_est), .o_aceito(w_canc_ok)
  );

  // Only the accept pulses matter for confirm/cancel.
  assign w_unused = ^{w_conf_est, w_canc_est};

  always_comb begin
    w_prox     = r_estado;
    w_code_n   = r_code;
    w_enL_n    = 1'b0;
    w_enC_n    = 1'b0;
    w_compra_n = 1'b0;
    w_exp_n    = 1'b0;
    w_tmo_fim  = (r_tmo == TMO_FIM);

    if (w_canc_ok) begin
      w_prox = S_LINHA;
    end else begin
      case (r_estado)
        S_LINHA: begin
          if (w_tecla_ok) begin
            w_code_n = onehot_para_code(tecla);
            w_enL_n  = 1'b1;
            w_prox   = S_SOLTA_L;
          end
        end
        S_SOLTA_L: if (w_tecla_est == '0) w_prox = S_COLUNA;
        S_COLUNA: begin
          // an accepted press outranks a timeout in the same cycle
          if (w_tecla_ok) begin
            w_code_n = onehot_para_code(tecla);
            w_enC_n  = 1'b1;
            w_prox   = S_SOLTA_C;
          end else if (w_tmo_fim) begin
            w_exp_n = 1'b1;
            w_prox  = S_LINHA;
          end
        end
        S_SOLTA_C: if (w_tecla_est == '0) w_prox = S_PRONTO;
        S_PRONTO: begin
          if (w_conf_ok) begin
            w_compra_n = 1'b1;
            w_prox     = S_LINHA;
          end else if (w_tmo_fim) begin
            w_exp_n = 1'b1;
            w_prox  = S_LINHA;
          end
        end
        default: w_prox = S_LINHA;
      endcase
    end

    // idle timer: runs only while parked in S_COLUNA/S_PRONTO with no key activity
    w_tmo_n = '0;
    if ((w_prox == r_estado) && (tecla == '0) &&
        ((r_estado == S_COLUNA) || (r_estado == S_PRONTO)))
      w_tmo_n = w_tmo_fim ? r_tmo : r_tmo + CW'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_estado  <= S_LINHA;
      r_tmo     <= '0;
      r_code    <= 2'b00;
      r_enL     <= 1'b0;
      r_enC     <= 1'b0;
      r_compra  <= 1'b0;
      r_expirou <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_tmo     <= w_tmo_n;
      r_code    <= w_code_n;
      r_enL     <= w_enL_n;
      r_enC     <= w_enC_n;
      r_compra  <= w_compra_n;
      r_expirou <= w_exp_n;
    end
  end

  assign code       = r_code;
  assign enL        = r_enL;
  assign enC        = r_enC;
  assign compra     = r_compra;
  assign expirou    = r_expirou;
  assign sel_valida = (r_estado == S_PRONTO);

endmodule

// File: tb/tb_seletor_teclado.sv
// Directed bench for seletor_teclado with DEBOUNCE_CYC=4, TIMEOUT_CYC=40.
module tb_seletor_teclado;
  import seletor_teclado_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] tecla;
  logic       confirma, cancela;
  logic [1:0] code;
  logic       enL, enC, sel_valida, compra, expirou;

  int n_vec = 0, n_err = 0;
  int n_enL = 0, n_enC = 0, n_compra = 0, n_exp = 0, n_ambos = 0;
  int b_enL, b_enC, b_compra, b_exp;

  seletor_teclado #(.DEBOUNCE_CYC(4), .TIMEOUT_CYC(40)) dut (
    .clk(clk), .clr(clr), .tecla(tecla), .confirma(confirma), .cancela(cancela),
    .code(code), .enL(enL), .enC(enC), .sel_valida(sel_valida),
    .compra(compra), .expirou(expirou)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enL) n_enL++;
    if (enC) n_enC++;
    if (compra) n_compra++;
    if (expirou) n_exp++;
    if (enL && enC) n_ambos++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_enL = n_enL; b_enC = n_enC; b_compra = n_compra; b_exp = n_exp;
  endtask

  task automatic press(input logic [3:0] p, input int hold);
    tecla = p;
    step(hold);
    tecla = 4'b0000;
    step(6);
  endtask

  initial begin
    clr = 1'b1; tecla = 4'b0000; confirma = 1'b0; cancela = 1'b0;
    step(2);
    chk("reset_outs", {27'd0, code, enL, enC, sel_valida, compra, expirou}, 32'd0);
    chk("reset_state", 32'(dut.r_estado), 32'(S_LINHA));
    clr = 1'b0;
    step(2);

    // full selection
    snap();
    tecla = 4'b0010;
    step(3);
    chk("enL_before_4th", 32'(enL), 32'd0);
    step(1);
    chk("enL_latency", 32'(enL), 32'd1);
    chk("row_code", 32'(code), 32'h1);
    step(2);
    tecla = 4'b0000;
    step(6);
    chk("state_coluna", 32'(dut.r_estado), 32'(S_COLUNA));
    press(4'b1000, 6);
    chk("enC_count", 32'(n_enC - b_enC), 32'd1);
    chk("col_code", 32'(code), 32'h3);
    chk("sel_valida_on", 32'(sel_valida), 32'd1);
    confirma = 1'b1;
    step(4);
    chk("compra_pulse", 32'(compra), 32'd1);
    chk("after_compra_state", 32'(dut.r_estado), 32'(S_LINHA));
    step(1);
    chk("compra_one_cycle", 32'(compra), 32'd0);
    confirma = 1'b0;
    step(6);
    chk("full_enL_count", 32'(n_enL - b_enL), 32'd1);

    // bounce rejection
    snap();
    for (int i = 0; i < 5; i++) begin
      tecla = 4'b0100; step(2);
      tecla = 4'b0000; step(2);
    end
    chk("bounce_no_enL", 32'(n_enL - b_enL), 32'd0);
    tecla = 4'b0100;
    step(4);
    chk("stable_enL", 32'(enL), 32'd1);
    chk("stable_code", 32'(code), 32'h2);
    tecla = 4'b0000;
    step(6);
    cancela = 1'b1;
    step(4);
    chk("cancel_coluna", 32'(dut.r_estado), 32'(S_LINHA));
    cancela = 1'b0;
    step(6);
    chk("cancel_no_enC", 32'(n_enC - b_enC), 32'd0);

    // multi-key and hold
    snap();
    tecla = 4'b0011;
    step(10);
    chk("multikey_no_strobe", 32'(n_enL - b_enL), 32'd0);
    tecla = 4'b0001;
    step(50);
    chk("hold_one_enL", 32'(n_enL - b_enL), 32'd1);
    chk("hold_code", 32'(code), 32'h0);
    chk("hold_no_enC", 32'(n_enC - b_enC), 32'd0);

    // timeout: release, then 40 idle cycles in S_COLUNA
    tecla = 4'b0000;
    step(6);
    step(38);
    chk("tmo_not_yet", 32'(expirou), 32'd0);
    chk("tmo_still_coluna", 32'(dut.r_estado), 32'(S_COLUNA));
    step(1);
    chk("tmo_expirou", 32'(expirou), 32'd1);
    chk("tmo_state", 32'(dut.r_estado), 32'(S_LINHA));
    step(1);
    chk("tmo_one_cycle", 32'(n_exp - b_exp), 32'd1);
    snap();
    press(4'b0100, 6);
    chk("after_tmo_enL", 32'(n_enL - b_enL), 32'd1);
    chk("after_tmo_no_enC", 32'(n_enC - b_enC), 32'd0);

    // cancel beats confirm in S_PRONTO
    press(4'b0001, 6);
    chk("pronto_sel", 32'(sel_valida), 32'd1);
    snap();
    confirma = 1'b1; cancela = 1'b1;
    step(4);
    chk("cancel_wins_state", 32'(dut.r_estado), 32'(S_LINHA));
    chk("cancel_sel_drop", 32'(sel_valida), 32'd0);
    confirma = 1'b0; cancela = 1'b0;
    step(6);
    chk("cancel_no_compra", 32'(n_compra - b_compra), 32'd0);
    chk("cancel_no_expirou", 32'(n_exp - b_exp), 32'd0);

    // async reset while in S_SOLTA_C
    snap();
    press(4'b0010, 6);
    tecla = 4'b1000;
    step(4);
    chk("pre_clr_enC", 32'(enC), 32'd1);
    step(1);
    chk("pre_clr_state", 32'(dut.r_estado), 32'(S_SOLTA_C));
    #3 clr = 1'b1;
    #1;
    chk("clr_outs", {27'd0, code, enL, enC, sel_valida, compra, expirou}, 32'd0);
    chk("clr_state", 32'(dut.r_estado), 32'(S_LINHA));
    #1 clr = 1'b0;
    tecla = 4'b0000;
    step(6);
    chk("post_clr_state", 32'(dut.r_estado), 32'(S_LINHA));
    chk("post_clr_enL", 32'(n_enL - b_enL), 32'd1);
    chk("never_both", 32'(n_ambos), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
